conv_row_scheduler: RTL
=======================

CONV_ROW_SCHEDULER -- requirements
Module: conv_row_scheduler

Interface
REQ-001 SHALL have parameters: INPUT_ROW_WIDTH, default 6, output-row counter width; INPUT_COL_WIDTH, default 6, output-column counter width; OUTPUT_CHANNEL_WIDTH, default 8, channel index width; TOTAL_ELEMENT_WIDTH, default 5, FIFO element-count width minus 1; FILL_THRESHOLD, default 9, minimum buffered elements before streaming; CH_PER_GROUP, default 4, output channels per pass.
REQ-002 SHALL have one clock and an asynchronous active-low reset, with ports i_clock input 1 (rising-edge clock) and i_reset input 1 (asynchronous active-low reset).
REQ-003 SHALL have ports: i_enable input 1, global advance enable; i_layer_start input 1, start request (sampled in IDLE only).
REQ-004 SHALL have ports: i_output_row input INPUT_ROW_WIDTH, rows per pass; i_output_col input INPUT_COL_WIDTH, columns per row; i_out_ch_start, i_out_ch_end input OUTPUT_CHANNEL_WIDTH each, channel range.
REQ-005 SHALL have ports: i_fifo_empty input 1; i_element_count input TOTAL_ELEMENT_WIDTH+1; i_read_data_valid input 1; i_reset_busy input 1; i_pe_ready input 1, consumer can accept a window.
REQ-006 SHALL have ports: o_start_transfer_process output 1; o_renable output 1; o_pe_valid output 1; o_row_count output INPUT_ROW_WIDTH; o_col_count output INPUT_COL_WIDTH; o_ch_group output OUTPUT_CHANNEL_WIDTH; o_layer_busy output 1; o_layer_done output 1.

Function
REQ-007 SHALL implement FSM states IDLE, WAIT_RB, START_ROW, FILL, STREAM, ROW_END, DONE; state and counters SHALL advance only when i_enable=1.
REQ-008 SHALL, in IDLE with i_layer_start=1, latch i_output_row, i_output_col, i_out_ch_start, i_out_ch_end, clear row/col/group counters, and go to WAIT_RB; these ports SHALL be ignored outside IDLE.
REQ-009 SHALL compute group_last = (end-start)>>2 (CH_PER_GROUP=4) from latched values, forced to 0 when end<start.
REQ-010 SHALL leave WAIT_RB when i_reset_busy=0: to DONE if latched rows or cols is 0, else to START_ROW.
REQ-011 SHALL assert o_start_transfer_process for exactly one cycle in START_ROW, then go to FILL.
REQ-012 SHALL leave FILL for STREAM when i_element_count >= FILL_THRESHOLD (unsigned compare).
REQ-013 SHALL drive o_renable = (state==STREAM) & i_enable & !i_fifo_empty & i_pe_ready, combinationally.
REQ-014 SHALL increment o_col_count on each cycle with o_renable=1; when o_renable=1 and col_count==cols-1, col_count SHALL wrap to 0 and the FSM SHALL go to ROW_END.
REQ-015 SHALL, in ROW_END (one cycle): if row_count<rows-1, increment row_count and go to START_ROW; else clear row_count and, if ch_group<group_last, increment ch_group and go to START_ROW, otherwise go to DONE.
REQ-016 SHALL pulse o_layer_done for one cycle in DONE, then return to IDLE.
REQ-017 SHALL drive o_layer_busy=1 in every state except IDLE.
REQ-018 SHALL drive o_pe_valid = i_read_data_valid & (state==STREAM or ROW_END).
REQ-019 SHALL, when i_enable=0, hold all state and counters and force o_renable=0 and o_start_transfer_process=0, without losing the pending START_ROW pulse.

Reset
REQ-020 SHALL, on i_reset=0 regardless of clock, enter IDLE and clear all counters and latched config; all outputs SHALL be 0 while in reset, including mid-layer.

Verification
REQ-021 Rows=2, cols=3, ch 0..3, FIFO always ready and count=9 -> 2 start pulses, 6 renable cycles, group stays 0, one o_layer_done.
REQ-022 Ch 0..11, rows=1, cols=2 -> o_ch_group steps 0,1,2, 3 start pulses, done after group 2.
REQ-023 Count held at 8 in FILL for 5 cycles, then 9 -> no renable until the cycle after count reaches 9.
REQ-024 In STREAM, toggle i_fifo_empty/i_pe_ready -> renable only when both permit; col_count never advances otherwise.
REQ-025 Cols=0 -> no start pulse, o_layer_done one cycle after i_reset_busy falls; i_enable=0 in START_ROW for 3 cycles -> pulse delayed, still exactly one.
REQ-026 Assert i_reset mid-STREAM -> immediate IDLE, all outputs 0; new i_layer_start restarts from row 0, group 0.

Source files
------------

// File: rtl/conv_row_scheduler.sv
// Row/channel-group scheduler for a convolution engine: walks output rows and
// columns for each channel group, gating FIFO reads on fill level and PE readiness.
module conv_row_scheduler #(
    parameter int INPUT_ROW_WIDTH      = 6,
    parameter int INPUT_COL_WIDTH      = 6,
    parameter int OUTPUT_CHANNEL_WIDTH = 8,
    parameter int TOTAL_ELEMENT_WIDTH  = 5,
    parameter int FILL_THRESHOLD       = 9,
    parameter int CH_PER_GROUP         = 4
) (
    input  logic                            i_clock,
    input  logic                            i_reset,
    input  logic                            i_enable,
    input  logic                            i_layer_start,
    input  logic [INPUT_ROW_WIDTH-1:0]      i_output_row,
    input  logic [INPUT_COL_WIDTH-1:0]      i_output_col,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0] i_out_ch_start,
    input  logic [OUTPUT_CHANNEL_WIDTH-1:0] i_out_ch_end,
    input  logic                            i_fifo_empty,
    input  logic [TOTAL_ELEMENT_WIDTH:0]    i_element_count,
    input  logic                            i_read_data_valid,
    input  logic                            i_reset_busy,
    input  logic                            i_pe_ready,
    output logic                            o_start_transfer_process,
    output logic                            o_renable,
    output logic                            o_pe_valid,
    output logic [INPUT_ROW_WIDTH-1:0]      o_row_count,
    output logic [INPUT_COL_WIDTH-1:0]      o_col_count,
    output logic [OUTPUT_CHANNEL_WIDTH-1:0] o_ch_group,
    output logic                            o_layer_busy,
    output logic                            o_layer_done
);

    localparam int GROUP_SHIFT = $clog2(CH_PER_GROUP);
    localparam logic [TOTAL_ELEMENT_WIDTH:0] FILL_LEVEL = (TOTAL_ELEMENT_WIDTH+1)'(FILL_THRESHOLD);

    typedef enum logic [2:0] {
        IDLE, WAIT_RB, START_ROW, FILL, STREAM, ROW_END, DONE
    } state_t;

    state_t                          state_reg, state_next;
    logic [INPUT_ROW_WIDTH-1:0]      rows_reg, rows_next;
    logic [INPUT_COL_WIDTH-1:0]      cols_reg, cols_next;
    logic [OUTPUT_CHANNEL_WIDTH-1:0] ch_start_reg, ch_start_next;
    logic [OUTPUT_CHANNEL_WIDTH-1:0] ch_end_reg, ch_end_next;
    logic [INPUT_ROW_WIDTH-1:0]      row_count_reg, row_count_next;
    logic [INPUT_COL_WIDTH-1:0]      col_count_reg, col_count_next;
    logic [OUTPUT_CHANNEL_WIDTH-1:0] ch_group_reg, ch_group_next;

    logic [OUTPUT_CHANNEL_WIDTH-1:0] ch_span;
    logic [OUTPUT_CHANNEL_WIDTH-1:0] group_last;
    logic [INPUT_ROW_WIDTH:0]        row_inc;
    logic [INPUT_COL_WIDTH:0]        col_inc;
    logic                            row_more;
    logic                            col_last;
    logic                            read_fire;

    // An inverted channel range collapses to a single group.
    assign ch_span    = ch_end_reg - ch_start_reg;
    assign group_last = (ch_end_reg < ch_start_reg) ? '0 : (ch_span >> GROUP_SHIFT);

    // Compare in one extra bit so rows/cols at full scale do not wrap.
    assign row_inc  = {1'b0, row_count_reg} + (INPUT_ROW_WIDTH+1)'(1);
    assign col_inc  = {1'b0, col_count_reg} + (INPUT_COL_WIDTH+1)'(1);
    assign row_more = row_inc < {1'b0, rows_reg};
    assign col_last = col_inc == {1'b0, cols_reg};

    assign read_fire = (state_reg == STREAM) && i_enable && !i_fifo_empty && i_pe_ready;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_reg     <= IDLE;
            rows_reg      <= '0;
            cols_reg      <= '0;
            ch_start_reg  <= '0;
            ch_end_reg    <= '0;
            row_count_reg <= '0;
            col_count_reg <= '0;
            ch_group_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            rows_reg      <= rows_next;
            cols_reg      <= cols_next;
            ch_start_reg  <= ch_start_next;
            ch_end_reg    <= ch_end_next;
            row_count_reg <= row_count_next;
            col_count_reg <= col_count_next;
            ch_group_reg  <= ch_group_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        rows_next      = rows_reg;
        cols_next      = cols_reg;
        ch_start_next  = ch_start_reg;
        ch_end_next    = ch_end_reg;
        row_count_next = row_count_reg;
        col_count_next = col_count_reg;
        ch_group_next  = ch_group_reg;

        if (i_enable) begin
            case (state_reg)
                IDLE: begin
                    if (i_layer_start) begin
                        rows_next      = i_output_row;
                        cols_next      = i_output_col;
                        ch_start_next  = i_out_ch_start;
                        ch_end_next    = i_out_ch_end;
                        row_count_next = '0;
                        col_count_next = '0;
                        ch_group_next  = '0;
                        state_next     = WAIT_RB;
                    end
                end
                WAIT_RB: begin
                    if (!i_reset_busy) begin
                        state_next = (rows_reg == '0 || cols_reg == '0) ? DONE : START_ROW;
                    end
                end
                START_ROW: state_next = FILL;
                FILL: begin
                    if (i_element_count >= FILL_LEVEL) begin
                        state_next = STREAM;
                    end
                end
                STREAM: begin
                    if (read_fire) begin
                        if (col_last) begin
                            col_count_next = '0;
                            state_next     = ROW_END;
                        end else begin
                            col_count_next = col_inc[INPUT_COL_WIDTH-1:0];
                        end
                    end
                end
                ROW_END: begin
                    if (row_more) begin
                        row_count_next = row_inc[INPUT_ROW_WIDTH-1:0];
                        state_next     = START_ROW;
                    end else begin
                        row_count_next = '0;
                        if (ch_group_reg < group_last) begin
                            ch_group_next = ch_group_reg + OUTPUT_CHANNEL_WIDTH'(1);
                            state_next    = START_ROW;
                        end else begin
                            state_next = DONE;
                        end
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // Pulses are qualified by enable so a stalled state emits them exactly once.
    assign o_start_transfer_process = (state_reg == START_ROW) && i_enable;
    assign o_renable                = read_fire;
    assign o_pe_valid               = i_read_data_valid && ((state_reg == STREAM) || (state_reg == ROW_END));
    assign o_row_count              = row_count_reg;
    assign o_col_count              = col_count_reg;
    assign o_ch_group               = ch_group_reg;
    assign o_layer_busy             = (state_reg != IDLE);
    assign o_layer_done             = (state_reg == DONE) && i_enable;

endmodule
